// File: rtl/dual_dac_play_sched_if.sv
// FIFO read-side bundle for both playback channels (A and B).
// master = scheduler (drives read enables), slave = FIFO side.
interface dual_dac_play_sched_if #(
  parameter int unsigned CNT_W = 13
);
  logic [CNT_W-1:0] rd_count_a;
  logic [CNT_W-1:0] rd_count_b;
  logic             empty_a;
  logic             empty_b;
  logic [7:0]       dout_a;
  logic [7:0]       dout_b;
  logic             rd_en_a;
  logic             rd_en_b;

  modport master (
    input  rd_count_a, rd_count_b, empty_a, empty_b, dout_a, dout_b,
    output rd_en_a, rd_en_b
  );

  modport slave (
    output rd_count_a, rd_count_b, empty_a, empty_b, dout_a, dout_b,
    input  rd_en_a, rd_en_b
  );
endinterface

// File: rtl/dual_dac_play_sched.sv
// Dual-channel DAC playback scheduler: prefill start, one read per clock, hold on underrun.
// Optional PLAY_UNDERRUN_CNT_EN compiles in 16-bit saturating underrun counters.
module dual_dac_play_sched #(
  parameter int unsigned CNT_W      = 13,
  parameter int unsigned START_LVL  = 4096,
  parameter int unsigned RESUME_LVL = 256,
  parameter int unsigned HOLD_MAX   = 2048,
  parameter logic [9:0]  IDLE_CODE  = 10'd512
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [1:0]                   play_en,
  input  logic                         sync_start,
  dual_dac_play_sched_if.master        fifo,
  output logic [9:0]                   da_data_a,
  output logic [9:0]                   da_data_b,
  output logic [1:0]                   playing,
  output logic [15:0]                  underrun_cnt_a,
  output logic [15:0]                  underrun_cnt_b
);

  localparam int unsigned      HoldW     = $clog2(HOLD_MAX);
  localparam logic [CNT_W-1:0] StartLvl  = CNT_W'(START_LVL);
  localparam logic [CNT_W-1:0] ResumeLvl = CNT_W'(RESUME_LVL);
  localparam logic [HoldW-1:0] HoldLast  = HoldW'(HOLD_MAX - 1);

  typedef enum logic [1:0] {StIdle, StPlay, StHold} state_e;

  state_e           state_q [2];
  state_e           state_d [2];
  logic [HoldW-1:0] hold_q  [2];
  logic [CNT_W-1:0] cnt     [2];
  logic [7:0]       dout    [2];
  logic [9:0]       da_q    [2];
  logic [9:0]       da_d    [2];
  logic [1:0]       empty;
  logic [1:0]       rd_en;
  logic [1:0]       vld_q;
  logic [1:0]       playing_q;
  logic             sync_ok;

  assign cnt[0]       = fifo.rd_count_a;
  assign cnt[1]       = fifo.rd_count_b;
  assign empty        = {fifo.empty_b, fifo.empty_a};
  assign dout[0]      = fifo.dout_a;
  assign dout[1]      = fifo.dout_b;
  assign fifo.rd_en_a = rd_en[0];
  assign fifo.rd_en_b = rd_en[1];
  assign da_data_a    = da_q[0];
  assign da_data_b    = da_q[1];
  assign playing      = playing_q;

  always_ff @(posedge clk) begin
    for (int ch = 0; ch < 2; ch++) begin
      if (rst) state_q[ch] <= StIdle;
      else     state_q[ch] <= state_d[ch];
    end
  end

  always_comb begin
    sync_ok = (play_en == 2'b11) && (cnt[0] >= StartLvl) && (cnt[1] >= StartLvl);
    for (int ch = 0; ch < 2; ch++) begin
      state_d[ch] = state_q[ch];
      unique case (state_q[ch])
        StIdle: begin
          if (sync_start ? sync_ok : (cnt[ch] >= StartLvl)) state_d[ch] = StPlay;
        end
        StPlay: begin
          if (empty[ch]) state_d[ch] = StHold;
        end
        StHold: begin
          // Resume wins over timeout when both fire together.
          if (cnt[ch] >= ResumeLvl)      state_d[ch] = StPlay;
          else if (hold_q[ch] == HoldLast) state_d[ch] = StIdle;
        end
        default: state_d[ch] = StIdle;
      endcase
      if (!play_en[ch]) state_d[ch] = StIdle;
    end
  end

  // Read straight from state and empty so an empty FIFO is never read.
  always_comb begin
    rd_en = 2'b00;
    for (int ch = 0; ch < 2; ch++) begin
      rd_en[ch] = play_en[ch] && (state_q[ch] == StPlay) && !empty[ch];
    end
  end

  always_comb begin
    for (int ch = 0; ch < 2; ch++) begin
      da_d[ch] = da_q[ch];
      if (state_d[ch] == StIdle) da_d[ch] = IDLE_CODE;
      else if (vld_q[ch])        da_d[ch] = {dout[ch], 2'b00};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q     <= 2'b00;
      playing_q <= 2'b00;
      for (int ch = 0; ch < 2; ch++) begin
        hold_q[ch] <= '0;
        da_q[ch]   <= IDLE_CODE;
      end
    end else begin
      vld_q <= rd_en;
      for (int ch = 0; ch < 2; ch++) begin
        hold_q[ch]    <= (state_q[ch] == StHold) ? hold_q[ch] + 1'b1 : '0;
        da_q[ch]      <= da_d[ch];
        playing_q[ch] <= (state_d[ch] != StIdle);
      end
    end
  end

`ifdef PLAY_UNDERRUN_CNT_EN
  logic [15:0] urun_q [2];

  always_ff @(posedge clk) begin
    for (int ch = 0; ch < 2; ch++) begin
      if (rst) begin
        urun_q[ch] <= '0;
      end else if ((state_q[ch] == StPlay) && (state_d[ch] == StHold) &&
                   (urun_q[ch] != 16'hFFFF)) begin
        urun_q[ch] <= urun_q[ch] + 16'd1;
      end
    end
  end

  assign underrun_cnt_a = urun_q[0];
  assign underrun_cnt_b = urun_q[1];
`else
  assign underrun_cnt_a = 16'd0;
  assign underrun_cnt_b = 16'd0;
`endif

endmodule

// File: doc/dual_dac_play_sched.md
# dual_dac_play_sched

Dual-channel playback scheduler in the DAC clock domain (1.024 MHz) between the two 8192x8 sample FIFOs (A, B) and the two 10-bit DAC ports. It decides when each channel starts draining its FIFO (prefill watermark), paces reads at one sample per clock, and rides out underruns by holding the last sample. It returns to mid-scale idle when data stops. An optional sync mode starts both channels on the same cycle, so A/B outputs stay phase-aligned.

## Interface
- CNT_W, 13, width of FIFO read-side data counts
- START_LVL, 4096, fill level at or above which an idle channel starts playing
- RESUME_LVL, 256, fill level at or above which a held channel resumes
- HOLD_MAX, 2048, max consecutive hold cycles before falling back to idle
- IDLE_CODE, 10'd512, DAC code while idle (mid-scale)

- clk  in  1  DAC-domain clock (clk_1024k)
- rst  in  1  synchronous reset, active-high
- play_en  in  2  per-channel enable, [0]=A, [1]=B
- sync_start  in  1  1 = both channels leave IDLE together
- rd_count_a / rd_count_b  in  CNT_W  FIFO read-side data count
- empty_a / empty_b  in  1  FIFO empty flags
- dout_a / dout_b  in  8  FIFO read data, valid 1 cycle after rd_en
- rd_en_a / rd_en_b  out  1  FIFO read enables
- da_data_a / da_data_b  out  10  DAC codes
- playing  out  2  channel in PLAY or HOLD
- underrun_cnt_a / underrun_cnt_b  out  16  underrun event counters (see Configuration)

## Operation
- Per-channel FSM, states IDLE, PLAY, HOLD. Reset: IDLE, all outputs 0 except da_data_* = IDLE_CODE.
- IDLE: rd_en=0, da_data=IDLE_CODE.
  - sync_start=0: go to PLAY when play_en[ch] and rd_count >= START_LVL.
  - sync_start=1: both channels go to PLAY in the same cycle, only when both enables are high and both counts are >= START_LVL. A channel already playing is unaffected.
- PLAY: rd_en = !empty (combinational from state and empty, so the block never reads an empty FIFO). When empty=1 in PLAY, the next state is HOLD.
- HOLD: rd_en=0; da_data keeps the last sample; a hold counter increments each cycle.
  - Goes to PLAY when rd_count >= RESUME_LVL.
  - Goes to IDLE when the hold counter reaches HOLD_MAX-1 with no resume.
  - Resume takes priority when both conditions hold in the same cycle.
  - The hold counter clears on every entry to HOLD.
- play_en[ch] low in any state: next state is IDLE and rd_en drops the same cycle. Samples still in the read pipeline are discarded and da_data goes to IDLE_CODE.
- Data path: a 1-bit valid pipeline tracks each rd_en. When the delayed valid is 1, da_data <= {dout,2'b00}; otherwise da_data holds its value (PLAY/HOLD) or takes IDLE_CODE (IDLE).
- Underrun event = each PLAY->HOLD transition. Counters saturate at 16'hFFFF.
- playing[ch] = state is PLAY or HOLD, registered.

## Timing
- rd_en asserted in cycle n → dout valid in cycle n+1 → da_data updated at the edge ending cycle n+1, visible in cycle n+2. Latency is 2 cycles.
- Start latency: count >= START_LVL sampled in cycle n → state PLAY and first rd_en in cycle n+1 → first sample on da_data in cycle n+3.
- Full-rate playback gives one sample per clock, with no bubbles while !empty.
- empty rising in PLAY: rd_en is 0 in that same cycle, state is HOLD in the next cycle, and the last valid sample is held with no glitch to IDLE_CODE.
- rst asserted mid-operation: at the next edge all state, pipelines and counters return to reset values. Underrun counters also clear.

## Configuration
- PLAY_UNDERRUN_CNT_EN defined: underrun_cnt_a/b implemented as 16-bit saturating counters.
- Not defined: counters and their logic are not compiled; underrun_cnt_a/b are tied to 16'd0. The FSM behaves identically either way.

## Test plan
- Prefill: play_en=2'b01, sync_start=0, rd_count_a ramps to 4096 with dout_a=8'hA5 → rd_en_a rises the cycle after the count reaches 4096; da_data_a goes 512 then 10'h294 two cycles later; channel B stays at 512.
- Underrun/resume: during PLAY force empty_a=1 for 10 cycles with count 0, then count 300 and empty_a=0 → rd_en_a is 0 while empty; da_data_a holds its last value; resume occurs when count >= 256; underrun_cnt_a=1.
- Hold timeout: empty_a held for 2048 cycles → state IDLE, da_data_a=512, playing[0]=0.
- Sync start: sync_start=1, count_a=5000, count_b=100, then count_b=4096 → neither channel starts until count_b reaches 4096; rd_en_a and rd_en_b then rise in the same cycle.
- Disable/reset mid-play: drop play_en[1] during PLAY → rd_en_b falls the same cycle and da_data_b=512 next cycle. Pulse rst → all outputs return to reset values and counters clear.
- Macro off: build without PLAY_UNDERRUN_CNT_EN and repeat the underrun scenario → underrun_cnt_a stays 0 and other outputs are identical.
